serial_adder_nor: RTL
=====================

Name: serial_adder_nor

Overview:
- Bit-serial N-bit adder built around a single NOR-only full-adder bit cell (`fulladder_nor`, port order: carry, sum, r, s, t).
- Loads two operands and a carry-in, then feeds one bit pair per clock, LSB first, into the bit cell.
- Holds the carry in a flip-flop between bits and assembles the sum in a shift register.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Sequential front end for the combinational adder cells, for area-minimal datapaths.

Parameters:
- N, 4, operand/sum width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  N  operand A, captured on accepted start
- b  input  N  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse, result valid
- sum  output  N  registered sum, stable between updates
- cout  output  1  registered carry-out

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE, busy = 0, done = 0, sum = 0, cout = 0. Internal a_sh, b_sh, s_sh, carry and cnt are all 0.
- Internal registers:
  - a_sh, b_sh: N-bit operand shift registers.
  - carry: 1-bit carry flip-flop.
  - s_sh: N-bit sum shift register.
  - cnt: counter of ceil(log2 N)+1 bits.
- Bit cell: exactly one `fulladder_nor` instance with inputs r = a_sh[0], s = b_sh[0], t = carry.
- No behavioural `+` is permitted.
- States:
  - IDLE:
    - busy = 0.
    - If start = 1: a_sh <= a, b_sh <= b, carry <= cin, cnt <= 0, go to SHIFT.
    - Otherwise hold.
  - SHIFT:
    - busy = 1. Each edge:
      - s_sh <= {cell_sum, s_sh[N-1:1]}
      - a_sh <= a_sh >> 1, b_sh <= b_sh >> 1
      - carry <= cell_carry
      - cnt <= cnt + 1
    - On the edge where cnt == N-1:
      - sum <= {cell_sum, s_sh[N-1:1]}
      - cout <= cell_carry
      - done <= 1
      - go to DONE.
  - DONE:
    - busy = 1, done = 1 for exactly this cycle.
    - Next edge: done <= 0, go to IDLE.
    - start is ignored in DONE.
- Latency:
  - start accepted at edge E0.
  - Shifting occupies edges E1..EN.
  - done is high in the cycle following EN.
  - Earliest next accepted start is at edge EN+2.
- start while busy: ignored. No effect on registers, not queued.
- Operand inputs a, b and cin are sampled only at the accept edge. Later changes have no effect on the operation in flight.
- sum and cout update only on the final SHIFT edge. They hold their previous value throughout SHIFT and IDLE, and until the next completion.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(N+1). No overflow flag; cout is the overflow.
- Reset asserted mid-operation: immediately returns to reset values. The in-flight result is discarded, no done pulse occurs, and sum/cout clear to 0.
- Reset deassertion is synchronous to clk by system assumption. The first edge after deassertion may accept start.

Test Plan:
- All cases use N = 4.
- Basic add: reset, then a=0101, b=0011, cin=0, start for 1 cycle. Required:
  - busy high 5 cycles.
  - done pulses once, 5 edges after the accept edge.
  - sum = 1000, cout = 0.
  - sum remains 0000 during SHIFT.
- Carry ripple: a=1111, b=0001, cin=0 -> sum = 0000, cout = 1.
- Carry-in full: a=1111, b=1111, cin=1 -> sum = 1111, cout = 1. Then a=0000, b=0000, cin=0 -> sum = 0000, cout = 0, and the previous result holds until that done.
- Start while busy: start 0101+0011, then pulse start with a=1111, b=1111 at SHIFT cycle 2 and in the DONE cycle. Required: single done, result 1000/0, no second operation begins.
- Reset mid-op: start 0111+0001, drop rst_n at SHIFT cycle 2 between clock edges. Required:
  - busy, done, sum and cout go to 0 immediately.
  - No done pulse.
  - After release, a new 0010+0010 produces sum = 0100, cout = 0.
- Exhaustive: all 512 (a, b, cin) combinations back-to-back, start each time busy=0 -> {cout, sum} matches a+b+cin on every done, with exactly one done per accepted start.

Source files
------------

// File: rtl/serial_adder_nor.sv
// Bit-serial N-bit adder: one NOR-only full-adder cell, LSB first,
// with the carry held in a flop between bits.

module fulladder_nor (
  output logic carry,
  output logic sum,
  input  logic r,
  input  logic s,
  input  logic t
);

  logic n1, n2, n3, xn;
  logic m1, m2, m3;

  // xn = ~(r ^ s); sum = xnor(xn, t) = r ^ s ^ t
  assign n1    = ~(r | s);
  assign n2    = ~(r | n1);
  assign n3    = ~(s | n1);
  assign xn    = ~(n2 | n3);
  assign m1    = ~(xn | t);
  assign m2    = ~(xn | m1);
  assign m3    = ~(t | m1);
  assign sum   = ~(m2 | m3);
  assign carry = ~(n1 | m1);

endmodule

module serial_adder_nor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t         st_q, st_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   s_sh_q, s_sh_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cnt_inc;
  logic           cell_sum, cell_carry;

  fulladder_nor u_fa (
    .carry (cell_carry),
    .sum   (cell_sum),
    .r     (a_sh_q[0]),
    .s     (b_sh_q[0]),
    .t     (carry_q)
  );

  // Ripple incrementer, keeps arithmetic out of the datapath
  always_comb begin : inc
    logic c;
    c = 1'b1;
    for (int i = 0; i < CW; i++) begin
      cnt_inc[i] = cnt_q[i] ^ c;
      c          = cnt_q[i] & c;
    end
  end

  always_comb begin
    st_d    = st_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          st_d    = SHIFT;
        end
      end
      SHIFT: begin
        s_sh_d  = {cell_sum, s_sh_q[N-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = cell_carry;
        cnt_d   = cnt_inc;
        if (cnt_q == CW'(N - 1)) begin
          sum_d  = {cell_sum, s_sh_q[N-1:1]};
          cout_d = cell_carry;
          st_d   = DONE;
        end
      end
      DONE: begin
        st_d = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (st_q != IDLE);
  assign done = (st_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
